nibble_mac_sequencer: RTL
=========================

NIBBLE_MAC_SEQUENCER -- requirements
Module: nibble_mac_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 20, result/accumulator width; legal range 16..32.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  nibble-load command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 SHALL have port cmd_sel  input  2  target nibble: 00 IN[3:0], 01 IN[7:4], 10 WEIGHT[3:0], 11 WEIGHT[7:4].
REQ-007 SHALL have port cmd_data  input  4  nibble value.
REQ-008 SHALL have port start  input  1  single-cycle request to multiply IN x WEIGHT.
REQ-009 SHALL have port busy  output  1  high in MUL and DONE.
REQ-010 SHALL have port acc_clr  input  1  clear accumulator; used only when ACCUM_EN is defined.
REQ-011 SHALL have port res_valid  output  1  result available.
REQ-012 SHALL have port res_ready  input  1  result consumed when res_valid & res_ready at a rising edge.
REQ-013 SHALL have port res_data  output  ACC_W  result, zero-extended, unsigned.

Function
REQ-014 SHALL implement states IDLE, MUL, DONE; no other reachable state.
REQ-015 cmd_ready SHALL be 1 in IDLE and DONE when start is 0, and 0 otherwise.
REQ-016 An accepted command SHALL write only the selected nibble of IN or WEIGHT; other bits unchanged.
REQ-017 start SHALL be honoured only in IDLE; it is ignored in MUL and DONE, with no queuing.
REQ-018 start and cmd_valid together in IDLE: start wins and the command is not accepted (cmd_ready = 0).
REQ-019 At the edge sampling start (edge N), the block SHALL copy IN and WEIGHT into working registers, clear the partial product and bit counter, and enter MUL.
REQ-020 MUL SHALL perform one unsigned shift-add iteration per cycle at edges N+1..N+8, LSB-first on the WEIGHT copy.
REQ-021 Edge N+9 SHALL register the 16-bit product into res_data and enter DONE; res_valid is 1 after edge N+9, a fixed 9-cycle latency.
REQ-022 IN and WEIGHT SHALL be unchanged by a multiply, so repeated starts reuse the loaded operands.
REQ-023 In DONE, res_valid and res_data SHALL hold stable until res_ready is sampled high; the block then returns to IDLE, with res_valid 0 on the next cycle.
REQ-024 Commands accepted in DONE SHALL update IN/WEIGHT without affecting res_data.
REQ-025 Product SHALL be exact: 0..0xFE01, no truncation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, IN = 0, WEIGHT = 0, working registers = 0, accumulator = 0, res_data = 0, res_valid = 0, busy = 0.
REQ-027 Reset asserted mid-MUL or in DONE SHALL abort the operation with no result emitted; cmd_ready is 1 after release.
REQ-028 Release SHALL be honoured at the first rising edge with rst_n high; no start is implied.

Configuration
REQ-029 Macro ACCUM_EN: when defined, edge N+9 SHALL set acc <= acc + product (ACC_W bits, modulo wrap) and res_data = new acc.
REQ-030 With ACCUM_EN, acc_clr high in IDLE SHALL zero acc at that edge; acc_clr together with start clears first, so the result equals the product alone.
REQ-031 Without ACCUM_EN, res_data SHALL equal the zero-extended product; acc_clr is ignored and no accumulator register exists.

Verification
REQ-032 Load IN = 0x12, WEIGHT = 0x34 via four commands, then pulse start -> res_valid exactly 9 cycles later, res_data = 0x3A8, busy high throughout.
REQ-033 IN = 0xFF, WEIGHT = 0xFF, res_ready held 0 for 5 cycles -> res_data = 0xFE01 held stable; start pulses during the hold are ignored; IDLE is entered 1 cycle after res_ready.
REQ-034 cmd_valid held high with cmd_sel = 00 during MUL -> cmd_ready = 0, IN unchanged; the command is accepted in the first DONE cycle.
REQ-035 Assert rst_n low at MUL edge N+4 -> all outputs 0 immediately, no res_valid after release; IN and WEIGHT read back 0 (0x00 x 0x07 start yields 0).
REQ-036 ACCUM_EN: acc_clr + start with 3x5, then 2x7 -> res_data 0x0F, then 0x1D; without ACCUM_EN -> 0x0F, then 0x0E.
REQ-037 start and cmd_valid in the same IDLE cycle -> multiply uses the old operands and the command is not accepted.

Source files
------------

// File: rtl/nibble_mac_sequencer.sv
// Nibble-loaded 8x8 shift-add multiplier with a valid/ready result port.
// Define ACCUM_EN to sum successive products into an ACC_W accumulator.
module nibble_mac_sequencer #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_sel,
  input  logic [3:0]       cmd_data,
  input  logic             start,
  output logic             busy,
  input  logic             acc_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       in_q, in_d;
  logic [7:0]       wt_q, wt_d;
  logic [15:0]      mcand_q, mcand_d;
  logic [7:0]       mplier_q, mplier_d;
  logic [15:0]      prod_q, prod_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] result_w;

  logic in_idle;
  logic in_mul;
  logic in_done;
  logic start_go;
  logic cmd_fire;
  logic fin;

  assign in_idle  = (state_q == S_IDLE);
  assign in_mul   = (state_q == S_MUL);
  assign in_done  = (state_q == S_DONE);
  assign start_go = in_idle && start;
  assign fin      = in_mul && (cnt_q == 4'd8);

  // Gated by rst_n so every output reads 0 while reset is held.
  assign cmd_ready = rst_n && (in_idle || in_done) && !start;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = in_mul || in_done;
  assign res_valid = in_done;
  assign res_data  = res_q;

  always_comb begin
    in_d = in_q;
    wt_d = wt_q;
    if (cmd_fire) begin
      unique case (cmd_sel)
        2'b00: in_d[3:0] = cmd_data;
        2'b01: in_d[7:4] = cmd_data;
        2'b10: wt_d[3:0] = cmd_data;
        2'b11: wt_d[7:4] = cmd_data;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {8'h00, in_q};
          mplier_d = wt_q;
          prod_d   = 16'h0000;
          cnt_d    = 4'd0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == 4'd8) begin
          res_d   = result_w;
          state_d = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ACCUM_EN
  logic [ACC_W-1:0] acc_q, acc_d;

  assign result_w = acc_q + ACC_W'(prod_q);

  // A clear alongside start lands at edge N, before the add at N+9.
  always_comb begin
    acc_d = acc_q;
    if (in_idle && acc_clr) begin
      acc_d = '0;
    end else if (fin) begin
      acc_d = result_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_acc_clr;

  assign unused_acc_clr = acc_clr;
  assign result_w       = ACC_W'(prod_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      in_q     <= 8'h00;
      wt_q     <= 8'h00;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      prod_q   <= 16'h0000;
      cnt_q    <= 4'd0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      wt_q     <= wt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  logic unused_start_go;
  assign unused_start_go = start_go;

endmodule
